// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO-fed UART transmitter slice.
//   uart_tx_state_t      : transmitter FSM state encoding
//   DEFAULT_CLKS_PER_BIT : default bit period in clock cycles
//   LINE_IDLE/LINE_STOP  : serial line levels for idle and stop bit
//   idxWidth()           : width of a counter that indexes 0..n-1 (min 1 bit)
// -----------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_tx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 16;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic LINE_STOP = 1'b1;

   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Counts clock cycles within one serial bit period.
//   clk   in  : clock
//   rst_n in  : asynchronous active-low reset
//   run   in  : counter advances while high, held at zero while low
//   tick  out : one-cycle pulse on the last cycle of each bit period
// -----------------------------------------------------------------------------
module bit_timer
   import fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   assign tick = run && (r_count == LAST_COUNT);

   // Wrapping on the last count means the next bit starts at zero in the
   // very next cycle, which is what lets frames run back to back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (!run || (r_count == LAST_COUNT)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from a show-ahead FIFO and sends each one as a serial frame:
// start bit, DATA_WIDTH data bits LSB first, optional even parity, stop bit.
//   clk          in  : clock
//   rst_n        in  : asynchronous active-low reset
//   tx_en        in  : allows new frames to start
//   fifo_empty   in  : FIFO has no entries
//   fifo_rd_data in  : FIFO head entry (valid while fifo_empty is low)
//   fifo_rd_en   out : one-cycle pop strobe
//   tx           out : serial line, idle high, driven from a flop
//   busy         out : a frame is in progress
//   frame_done   out : pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
   import fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_WIDTH   = 8,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int IDX_W = idxWidth(DATA_WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   uart_tx_state_t        r_state;
   uart_tx_state_t        w_nextState;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_nextShift;
   logic [IDX_W-1:0]      r_bitIdx;
   logic [IDX_W-1:0]      w_nextBitIdx;
   logic                  r_parity;
   logic                  w_nextParity;
   logic                  r_tx;
   logic                  w_nextTx;
   logic                  w_run;
   logic                  w_tick;
   logic                  w_canPop;
   logic                  w_pop;
   logic                  w_done;

   assign w_run = (r_state != ST_IDLE);

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bitTimer (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (w_run),
      .tick (w_tick)
   );

   // Gating with rst_n keeps the pop strobe quiet while reset is held.
   assign w_canPop = rst_n && tx_en && !fifo_empty;

   // Next-state logic. A pop latches the head entry and its parity at the
   // same edge that enters START, so later changes on the FIFO port are
   // ignored. The line level for the next cycle is derived from the next
   // state so tx can be registered without adding latency.
   always_comb begin
      w_nextState  = r_state;
      w_nextShift  = r_shift;
      w_nextBitIdx = r_bitIdx;
      w_nextParity = r_parity;
      w_pop        = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_canPop) begin
               w_pop        = 1'b1;
               w_nextShift  = fifo_rd_data;
               w_nextParity = ^fifo_rd_data;
               w_nextState  = ST_START;
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_nextState  = ST_DATA;
               w_nextBitIdx = '0;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               w_nextShift = r_shift >> 1;
               if (r_bitIdx == LAST_IDX) begin
                  w_nextState = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  w_nextBitIdx = r_bitIdx + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (w_tick) begin
               w_nextState = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               w_done = 1'b1;
               if (w_canPop) begin
                  w_pop        = 1'b1;
                  w_nextShift  = fifo_rd_data;
                  w_nextParity = ^fifo_rd_data;
                  w_nextState  = ST_START;
               end else begin
                  w_nextState = ST_IDLE;
               end
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase

      case (w_nextState)
         ST_START:  w_nextTx = 1'b0;
         ST_DATA:   w_nextTx = w_nextShift[0];
         ST_PARITY: w_nextTx = w_nextParity;
         ST_STOP:   w_nextTx = LINE_STOP;
         default:   w_nextTx = LINE_IDLE;
      endcase
   end

   // State, datapath and line register. Reset drops the in-flight byte and
   // returns the line high without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_shift  <= '0;
         r_bitIdx <= '0;
         r_parity <= 1'b0;
         r_tx     <= LINE_IDLE;
      end else begin
         r_state  <= w_nextState;
         r_shift  <= w_nextShift;
         r_bitIdx <= w_nextBitIdx;
         r_parity <= w_nextParity;
         r_tx     <= w_nextTx;
      end
   end

   assign fifo_rd_en = w_pop;
   assign tx         = r_tx;
   assign busy       = w_run;
   assign frame_done = w_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Two transmitters (parity off / parity on) share clock, reset and tx_en and
// are fed identical byte streams from FIFO models kept in this bench. Written
// bytes are queued as expected frames; a negedge monitor pops them on each
// pop strobe and compares the serial waveform against a bit-level model.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

   localparam int CPB  = 4;
   localparam int DW   = 8;
   localparam int LEN0 = (DW + 2) * CPB;
   localparam int LEN1 = (DW + 3) * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       txEn = 1'b0;
   logic [1:0] fifoEmpty = 2'b11;
   logic [7:0] fifoData [2];
   logic       rdEn0, rdEn1, tx0, tx1, busy0, busy1, done0, done1;
   logic [1:0] rdEn, txLine, busyO, doneO;

   assign rdEn   = {rdEn1, rdEn0};
   assign txLine = {tx1, tx0};
   assign busyO  = {busy1, busy0};
   assign doneO  = {done1, done0};

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .tx_en(txEn), .fifo_empty(fifoEmpty[0]),
      .fifo_rd_data(fifoData[0]), .fifo_rd_en(rdEn0), .tx(tx0),
      .busy(busy0), .frame_done(done0));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_en(txEn), .fifo_empty(fifoEmpty[1]),
      .fifo_rd_data(fifoData[1]), .fifo_rd_en(rdEn1), .tx(tx1),
      .busy(busy1), .frame_done(done1));

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   logic [7:0] fq0 [$];
   logic [7:0] fq1 [$];
   logic [7:0] eq0 [$];
   logic [7:0] eq1 [$];

   int         frames [2] = '{0, 0};
   int         popCount [2] = '{0, 0};
   int         popsApplied [2] = '{0, 0};
   int         kIdx [2] = '{0, 0};
   int         badCnt [2] = '{0, 0};
   bit         inFrame [2] = '{1'b0, 1'b0};
   logic [7:0] curByte [2];
   longint     lastPop [2] = '{0, 0};
   longint     cyc = 0;
   int         totalPushed = 0;

   function automatic int lenOf(input int l);
      return (l == 0) ? LEN0 : LEN1;
   endfunction

   // Serial level for bit slot bitNum of a frame carrying b.
   function automatic logic expTx(input logic [7:0] b, input int bitNum, input bit par);
      if (bitNum == 0) return 1'b0;
      if (bitNum <= DW) return b[bitNum-1];
      if (par && bitNum == DW + 1) return ^b;
      return 1'b1;
   endfunction

   function automatic int expSize(input int l);
      return (l == 0) ? eq0.size() : eq1.size();
   endfunction

   function automatic logic [7:0] expPop(input int l);
      if (l == 0) return eq0.pop_front();
      return eq1.pop_front();
   endfunction

   // Monitor / scoreboard.
   always @(negedge clk) begin
      cyc++;
      for (int l = 0; l < 2; l++) begin
         bit justDone;
         justDone = 1'b0;
         if (!rst_n) begin
            inFrame[l] = 1'b0;
         end else begin
            if (inFrame[l]) begin
               kIdx[l]++;
               if (txLine[l] !== expTx(curByte[l], kIdx[l] / CPB, l == 1) || busyO[l] !== 1'b1)
                  badCnt[l]++;
               if (doneO[l] === 1'b1) begin
                  compared++;
                  if (kIdx[l] != lenOf(l) - 1 || badCnt[l] != 0) begin
                     mismatched++;
                     $display("[TB] FAIL frame lane%0d byte %02h: done at cycle %0d with %0d bad cycles, required cycle %0d with 0 bad",
                              l, curByte[l], kIdx[l], badCnt[l], lenOf(l) - 1);
                  end
                  inFrame[l] = 1'b0;
                  frames[l]++;
                  justDone = 1'b1;
               end else if (kIdx[l] >= lenOf(l) - 1) begin
                  compared++;
                  mismatched++;
                  $display("[TB] FAIL frame_done lane%0d: got 0 at cycle %0d, required 1", l, kIdx[l]);
                  inFrame[l] = 1'b0;
               end
            end else if (rdEn[l] !== 1'b1) begin
               compared++;
               if (txLine[l] !== 1'b1 || busyO[l] !== 1'b0 || doneO[l] !== 1'b0) begin
                  mismatched++;
                  $display("[TB] FAIL idle lane%0d: tx/busy/done = %b/%b/%b, required 1/0/0",
                           l, txLine[l], busyO[l], doneO[l]);
               end
            end
            if (rdEn[l] === 1'b1) begin
               compared++;
               if (fifoEmpty[l] !== 1'b0 || expSize(l) == 0 || inFrame[l]) begin
                  mismatched++;
                  $display("[TB] FAIL pop lane%0d: empty=%b queued=%0d midframe=%0d, required a queued entry between frames",
                           l, fifoEmpty[l], expSize(l), inFrame[l]);
               end else begin
                  curByte[l] = expPop(l);
               end
               if (justDone) begin
                  compared++;
                  if (cyc - lastPop[l] != longint'(lenOf(l))) begin
                     mismatched++;
                     $display("[TB] FAIL pop spacing lane%0d: got %0d, required %0d",
                              l, cyc - lastPop[l], lenOf(l));
                  end
               end
               inFrame[l] = 1'b1;
               kIdx[l]    = -1;
               badCnt[l]  = 0;
               lastPop[l] = cyc;
               popCount[l]++;
            end
         end
      end
   end

   task automatic updFifo();
      fifoEmpty[0] = (fq0.size() == 0);
      fifoEmpty[1] = (fq1.size() == 0);
      fifoData[0]  = (fq0.size() != 0) ? fq0[0] : 8'($urandom);
      fifoData[1]  = (fq1.size() != 0) ? fq1[0] : 8'($urandom);
   endtask

   // Advance one clock; pops seen by the monitor take effect after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      while (popsApplied[0] < popCount[0]) begin
         if (fq0.size() != 0) void'(fq0.pop_front());
         popsApplied[0]++;
      end
      while (popsApplied[1] < popCount[1]) begin
         if (fq1.size() != 0) void'(fq1.pop_front());
         popsApplied[1]++;
      end
      updFifo();
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      fq0.push_back(b);
      fq1.push_back(b);
      eq0.push_back(b);
      eq1.push_back(b);
      totalPushed++;
      updFifo();
   endtask

   task automatic checkOutput(input string name, input int got, input int exp);
      compared++;
      if (got != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic waitFrames(input int t0, input int t1, input int budget);
      int n;
      n = 0;
      while ((frames[0] < t0 || frames[1] < t1) && n < budget) begin
         step();
         n++;
      end
      checkOutput("frames reached", int'(frames[0] >= t0 && frames[1] >= t1), 1);
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (!(fq0.size() == 0 && fq1.size() == 0 && busyO == 2'b00) && n < budget) begin
         step();
         n++;
      end
      checkOutput("drained", int'(fq0.size() == 0 && fq1.size() == 0 && busyO == 2'b00), 1);
   endtask

   task automatic waitPop(input int p0, input int budget);
      int n;
      n = 0;
      while (popCount[0] == p0 && n < budget) begin
         step();
         n++;
      end
      checkOutput("pop seen", int'(popCount[0] != p0), 1);
   endtask

   initial begin
      int p0, f0, f1;
      updFifo();
      txEn = 1'b1;
      applyStimulus(8'hA5);
      repeat (4) step();
      for (int l = 0; l < 2; l++) begin
         checkOutput($sformatf("reset tx lane%0d", l), int'(txLine[l]), 1);
         checkOutput($sformatf("reset busy lane%0d", l), int'(busyO[l]), 0);
         checkOutput($sformatf("reset rd_en lane%0d", l), int'(rdEn[l]), 0);
         checkOutput($sformatf("reset frame_done lane%0d", l), int'(doneO[l]), 0);
      end
      rst_n = 1'b1;

      // Basic frame and parity frames
      waitFrames(1, 1, 200);
      applyStimulus(8'h01);
      waitFrames(2, 2, 200);

      // Back-to-back
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      applyStimulus(8'h3C);
      waitFrames(5, 5, 500);

      // Empty FIFO: nothing happens
      repeat (50) step();
      checkOutput("empty pops lane0", popCount[0], 5);
      checkOutput("empty pops lane1", popCount[1], 5);

      // tx_en dropped during DATA
      applyStimulus(8'h5A);
      applyStimulus(8'hC3);
      p0 = popCount[0];
      f0 = frames[0];
      f1 = frames[1];
      waitPop(p0, 100);
      repeat (12) step();
      txEn = 1'b0;
      repeat (100) step();
      checkOutput("txen-drop frames lane0", frames[0], f0 + 1);
      checkOutput("txen-drop frames lane1", frames[1], f1 + 1);
      checkOutput("txen-drop pops lane0", popCount[0], p0 + 1);
      checkOutput("txen-drop queued lane1", fq1.size(), 1);
      txEn = 1'b1;
      waitIdle(300);

      // Reset during data bit 3
      applyStimulus(8'h96);
      applyStimulus(8'hE7);
      p0 = popCount[0];
      waitPop(p0, 100);
      repeat (17) step();
      rst_n = 1'b0;
      #1;
      for (int l = 0; l < 2; l++) begin
         checkOutput($sformatf("midreset tx lane%0d", l), int'(txLine[l]), 1);
         checkOutput($sformatf("midreset busy lane%0d", l), int'(busyO[l]), 0);
      end
      repeat (3) step();
      rst_n = 1'b1;
      f0 = frames[0];
      f1 = frames[1];
      waitFrames(f0 + 1, f1 + 1, 300);
      checkOutput("post-reset pops lane0", popCount[0], p0 + 2);

      // Randomized traffic
      for (int i = 0; i < 24; i++) begin
         applyStimulus(8'($urandom));
         txEn = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(0, 50)) step();
      end
      txEn = 1'b1;
      waitIdle(4000);
      repeat (5) step();
      checkOutput("total frames lane0", frames[0], totalPushed - 1);
      checkOutput("total frames lane1", frames[1], totalPushed - 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
